// File: rtl/wb_arb_pkg.sv
// Shared types and defaults for the debug/CPU Wishbone arbiter.
// Owner states, grant encodings and tracker sizing defaults.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN0  = 2'd1,
        ST_OWN1  = 2'd2,
        ST_ABORT = 2'd3
    } arb_state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    localparam int DEF_PEND_W  = 4;
    localparam int DEF_TIMEOUT = 1023;

endpackage

// File: rtl/wb_pending_tracker.sv
// Outstanding-request counter with saturation flag and ack watchdog.
// The watchdog only runs while requests are in flight and nothing moves.
module wb_pending_tracker import wb_arb_pkg::*; #(
    parameter int PEND_W  = DEF_PEND_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_accept,
    input  logic i_resp,
    input  logic i_clear,
    output logic o_pending_nz,
    output logic o_full,
    output logic o_timeout
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    logic [PEND_W-1:0] r_pending;
    logic [TW-1:0]     r_timer;
    logic              w_nz;

    assign w_nz = |r_pending;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n || i_clear) begin
            r_pending <= '0;
        end else if (i_accept && !i_resp) begin
            r_pending <= r_pending + 1'b1;
        end else if (i_resp && !i_accept && w_nz) begin
            r_pending <= r_pending - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n || i_clear || i_accept || i_resp || !w_nz) begin
            r_timer <= '0;
        end else if (r_timer != TMAX) begin
            r_timer <= r_timer + 1'b1;
        end
    end

    assign o_pending_nz = w_nz;
    assign o_full       = &r_pending;
    assign o_timeout    = w_nz && (r_timer == TMAX);

endmodule

// File: rtl/wb_dbg_arbiter.sv
// Two-master pipelined Wishbone arbiter: debug loader (m0) and CPU (m1).
// Ownership is held until the owner drops cyc; a watchdog aborts dead slaves.
module wb_dbg_arbiter import wb_arb_pkg::*; #(
    parameter bit PRIO_M0 = 1'b1,
    parameter int PEND_W  = DEF_PEND_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_m0_cyc,
    input  logic        i_m0_stb,
    input  logic        i_m0_we,
    input  logic [3:0]  i_m0_sel,
    input  logic [29:0] i_m0_addr,
    input  logic [31:0] i_m0_data,
    output logic        o_m0_stall,
    output logic        o_m0_ack,
    output logic        o_m0_err,
    output logic [31:0] o_m0_data,
    input  logic        i_m1_cyc,
    input  logic        i_m1_stb,
    input  logic        i_m1_we,
    input  logic [3:0]  i_m1_sel,
    input  logic [29:0] i_m1_addr,
    input  logic [31:0] i_m1_data,
    output logic        o_m1_stall,
    output logic        o_m1_ack,
    output logic        o_m1_err,
    output logic [31:0] o_m1_data,
    output logic        o_s_cyc,
    output logic        o_s_stb,
    output logic        o_s_we,
    output logic [3:0]  o_s_sel,
    output logic [29:0] o_s_addr,
    output logic [31:0] o_s_data,
    input  logic        i_s_stall,
    input  logic        i_s_ack,
    input  logic        i_s_err,
    input  logic [31:0] i_s_data,
    output logic [1:0]  o_grant
);

    arb_state_t r_state;
    logic [1:0] r_grant;
    logic       r_owner;

    logic        w_own0;
    logic        w_own1;
    logic        w_owning;
    logic        w_live;
    logic        w_cyc;
    logic        w_stb;
    logic        w_we;
    logic [3:0]  w_sel;
    logic [29:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_nz;
    logic        w_full;
    logic        w_timeout;
    logic        w_accept;
    logic        w_resp;
    logic        w_ack;
    logic        w_err;
    logic        w_stall;

    assign w_own0   = (r_state == ST_OWN0);
    assign w_own1   = (r_state == ST_OWN1);
    assign w_owning = w_own0 | w_own1;

    // r_owner stays valid through ABORT so the owner's cyc can be watched
    assign w_cyc   = r_owner ? i_m1_cyc  : i_m0_cyc;
    assign w_stb   = r_owner ? i_m1_stb  : i_m0_stb;
    assign w_we    = r_owner ? i_m1_we   : i_m0_we;
    assign w_sel   = r_owner ? i_m1_sel  : i_m0_sel;
    assign w_addr  = r_owner ? i_m1_addr : i_m0_addr;
    assign w_wdata = r_owner ? i_m1_data : i_m0_data;

    assign w_live = w_owning & w_cyc & ~w_timeout;

    assign o_s_cyc  = w_live;
    assign o_s_stb  = w_live & w_stb & ~w_full;
    assign o_s_we   = w_owning & w_we;
    assign o_s_sel  = w_owning ? w_sel   : 4'h0;
    assign o_s_addr = w_owning ? w_addr  : 30'h0;
    assign o_s_data = w_owning ? w_wdata : 32'h0;

    assign w_accept = o_s_stb & ~i_s_stall;
    assign w_resp   = w_live & w_nz & (i_s_ack | i_s_err);
    assign w_ack    = w_live & w_nz & i_s_ack;
    assign w_err    = (w_live & w_nz & i_s_err) | w_timeout;
    assign w_stall  = ~w_live | i_s_stall | w_full;

    assign o_m0_stall = w_own0 ? w_stall  : 1'b1;
    assign o_m0_ack   = w_own0 & w_ack;
    assign o_m0_err   = w_own0 & w_err;
    assign o_m0_data  = w_own0 ? i_s_data : 32'h0;

    assign o_m1_stall = w_own1 ? w_stall  : 1'b1;
    assign o_m1_ack   = w_own1 & w_ack;
    assign o_m1_err   = w_own1 & w_err;
    assign o_m1_data  = w_own1 ? i_s_data : 32'h0;

    assign o_grant = r_grant;

    wb_pending_tracker #(
        .PEND_W  (PEND_W),
        .TIMEOUT (TIMEOUT)
    ) u_track (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_accept     (w_accept),
        .i_resp       (w_resp),
        .i_clear      (~w_live),
        .o_pending_nz (w_nz),
        .o_full       (w_full),
        .o_timeout    (w_timeout)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
            r_grant <= GNT_NONE;
            r_owner <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (i_m0_cyc && (PRIO_M0 || !i_m1_cyc)) begin
                        r_state <= ST_OWN0;
                        r_grant <= GNT_M0;
                        r_owner <= 1'b0;
                    end else if (i_m1_cyc) begin
                        r_state <= ST_OWN1;
                        r_grant <= GNT_M1;
                        r_owner <= 1'b1;
                    end
                end
                ST_OWN0, ST_OWN1: begin
                    if (w_timeout) begin
                        r_state <= ST_ABORT;
                        r_grant <= GNT_NONE;
                    end else if (!w_cyc) begin
                        r_state <= ST_IDLE;
                        r_grant <= GNT_NONE;
                    end
                end
                ST_ABORT: begin
                    if (!w_cyc) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= GNT_NONE;
                end
            endcase
        end
    end

endmodule

// File: doc/wb_dbg_arbiter.md
Name: wb_dbg_arbiter

Overview:
Two-master, one-slave pipelined Wishbone arbiter directly downstream of the UART/ihex debug master port. Merges the debug loader bus (master 0) with the CPU data bus (master 1) onto the shared memory/peripheral bus. It tracks outstanding requests so the grant never switches mid-transaction. It also enforces an ack timeout, so a dead slave cannot hang the serial loader.

Parameters:
PRIO_M0, 1, 1 = master 0 wins simultaneous requests from idle; 0 = master 1 wins
PEND_W, 4, width of outstanding-request counter (max 2^PEND_W-1 in flight)
TIMEOUT, 1023, cycles with requests pending and no ack/err before abort (≥2)

Ports:
i_clk  input  1  clock
i_reset_n  input  1  synchronous active-low reset
i_mN_cyc, i_mN_stb, i_mN_we (N=0,1)  input  1 each  master N bus cycle, strobe, write enable
i_mN_sel (N=0,1)  input  4  master N byte selects
i_mN_addr (N=0,1)  input  30  master N word address
i_mN_data (N=0,1)  input  32  master N write data
o_mN_stall, o_mN_ack, o_mN_err (N=0,1)  output  1 each  master N stall, ack, error
o_mN_data (N=0,1)  output  32  master N read data
o_s_cyc, o_s_stb, o_s_we  output  1 each  slave cycle, strobe, write enable
o_s_sel  output  4  slave byte selects
o_s_addr  output  30  slave word address
o_s_data  output  32  slave write data
i_s_stall, i_s_ack, i_s_err  input  1 each  slave stall, ack, error
i_s_data  input  32  slave read data
o_grant  output  2  one-hot current owner {m1,m0}; 00 when idle/abort

Behaviour:
- Reset (i_reset_n=0 at posedge): state IDLE, pending=0, timer=0. Outputs: o_s_cyc=o_s_stb=0, o_mN_stall=1, o_mN_ack=o_mN_err=0, o_mN_data=0, o_grant=00.
- Clock states: IDLE, OWN0, OWN1, ABORT. Grant is registered.
- IDLE: all masters see stall=1. If any i_mN_cyc is high at cycle T, go to OWNn at T+1. When both request, PRIO_M0 decides.
- Slave-side latency: the slave sees cyc/stb from the winner no earlier than T+1.
- OWNn routing: o_s_* = master n's signals, combinational from the registered state. Master n gets i_s_stall/ack/err/data. The other master gets stall=1, ack=0, err=0, data=0.
- Accept: o_s_stb & !o_s_stall gives pending+1. An i_s_ack or i_s_err gives pending-1. Both in the same cycle leave pending unchanged.
- Ack or err with pending=0 is ignored and is not forwarded.
- Saturation: when pending = 2^PEND_W-1, force the owner's stall=1 and o_s_stb=0 until a response arrives.
- Release: the owner drops i_mN_cyc, either normally or by abandonment with pending>0.
  - That same cycle, o_s_cyc=0.
  - Next cycle: state IDLE, pending=0.
  - Responses still arriving are dropped.
- Re-arbitration: there is none while in OWNn, even if the other master is requesting. Fairness is the masters' job.
- Timeout timer: cleared on accept, ack, err, or pending=0. Otherwise it increments while pending>0.
- Timeout action: when the timer reaches TIMEOUT, pulse o_mN_err=1 to the owner for exactly one cycle. On the same cycle, force o_s_cyc=0, clear pending, and enter ABORT.
- ABORT: slave cyc/stb=0, owner stall=1, no ack/err. Move to IDLE the cycle after the owner's cyc is seen low.
- o_s_stb is always qualified by o_s_cyc, so stb=1 never appears with cyc=0.
- A reset mid-transaction drops o_s_cyc immediately, on the reset cycle's registered outputs.

Decomposition:
- Package wb_arb_pkg: state enum (IDLE, OWN0, OWN1, ABORT), grant encodings, default TIMEOUT/PEND_W constants.
- Sub-module wb_pending_tracker: pending counter, saturation flag, and timeout timer. Inputs: accept, resp, clear. Outputs: pending_nz, full, timeout pulse.
- The muxing and FSM live in the top module.

Test Plan:
- Reset at 0: m0 cyc+stb rises at T → o_grant=01 at T+1. Write addr 0x0000010, data 0xDEADBEEF reaches the slave. The ack returns to m0 only. m1 sees stall=1 throughout.
- m0 and m1 request in the same cycle, PRIO_M0=1 → m0 is granted. After m0 drops cyc: IDLE one cycle, then o_grant=10.
- m1 issues 3 pipelined reads, slave acks 0x11, 0x22, 0x33 → m1 gets 3 acks with that data. Pending goes 1,2,3,…,0. An m0 request during this time stays stalled until m1 drops cyc.
- PEND_W=2, slave never acks, 5 strobes → 3 accepted, then forced stall. After TIMEOUT=8 idle cycles → single err pulse, o_s_cyc=0, ABORT. Master drops cyc → IDLE.
- Owner drops cyc with pending=2, then the slave acks late → acks are not forwarded to anyone. pending=0 in IDLE.
- Same-cycle accept and ack at pending=1 → pending stays 1. Stray i_s_ack in IDLE → no o_mN_ack.
